// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver, 16x oversampled with 3-sample majority vote per bit.
// Holds the last good byte with a valid flag; sticky framing-error and overrun flags.
module uart_rx_oversampled #(
    parameter int unsigned FREQ_MHZ = 60,
    parameter int unsigned BAUDS    = 115200,
    parameter int unsigned DIV      = (FREQ_MHZ * 1000000 + BAUDS * 8) / (BAUDS * 16)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          state_q;
    logic            rx_meta_q;
    logic            rxs_q;
    logic [CntW-1:0] div_q;
    logic [3:0]      s_q;
    logic [2:0]      b_q;
    logic            smp7_q;
    logic            smp8_q;
    logic [7:0]      shift_q;
    logic [7:0]      rx_data_q;
    logic            valid_q;
    logic            frame_err_q;
    logic            overrun_q;

    logic tick;
    logic majority;
    logic decide;
    logic in_frame;

    assign tick     = (div_q == CntMax);
    assign in_frame = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
    // Third vote is the live synchronised sample at s=9.
    assign majority = (smp7_q & smp8_q) | (smp7_q & rxs_q) | (smp8_q & rxs_q);
    assign decide   = in_frame && tick && (s_q == 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            div_q       <= '0;
            s_q         <= 4'd0;
            b_q         <= 3'd0;
            smp7_q      <= 1'b1;
            smp8_q      <= 1'b1;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;

            // Realign the oversample phase to the detected start edge.
            if ((state_q == StIdle && !rxs_q) || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end

            if (in_frame && tick) begin
                s_q <= s_q + 4'd1;
                if (s_q == 4'd7) smp7_q <= rxs_q;
                if (s_q == 4'd8) smp8_q <= rxs_q;
            end

            if (rd) begin
                valid_q     <= 1'b0;
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (!rxs_q) begin
                        state_q <= StStart;
                        s_q     <= 4'd0;
                    end
                end
                StStart: begin
                    if (decide) begin
                        if (majority) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StData;
                            b_q     <= 3'd0;
                        end
                    end
                end
                StData: begin
                    if (decide) begin
                        shift_q <= {majority, shift_q[7:1]};
                        if (b_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            b_q <= b_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    if (decide) begin
                        if (majority) begin
                            rx_data_q <= shift_q;
                            valid_q   <= 1'b1;
                            if (valid_q && !rd) overrun_q <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end
                end
                StBreak: begin
                    if (rxs_q) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
